// File: rtl/pong_game_engine.sv
// pong_game_engine
// Pong core: holds both paddles, the ball, the two scores and the
// serve/play/game-over sequencing, and renders everything into a
// registered 8-bit pixel stream driven by the display counters.
//
// Ports:
//   clk                       pixel clock
//   rst_n                     asynchronous active-low reset
//   start                     level, starts a game from IDLE or GAME_OVER
//   move_up/down_p0, _p1      player controls, left (p0) and right (p1)
//   select_l/r_player         1 = paddle player-driven, 0 = tracker-driven
//   col_counter, row_counter  current pixel position
//   rgb                       pixel colour, one cycle after the counters
//   score_l, score_r          scores, saturate at WIN_SCORE
//   game_over                 high while in GAME_OVER
//
// Optional feature: define CENTER_NET_EN to draw a dashed centre net.
//
// state     | meaning
// IDLE      | waiting for start, ball held at centre
// SERVE     | ball held at centre for SERVE_FRAMES ticks
// PLAY      | ball in motion, bounces, hits and misses
// POINT     | one tick after a miss, ball recentred
// GAME_OVER | a side reached WIN_SCORE, ball hidden, scores frozen
module pong_game_engine #(
    parameter int          DISP_COLS           = 800,
    parameter int          DISP_ROWS           = 600,
    parameter int          PADDLE_HEIGHT       = 40,
    parameter int          PADDLE_WIDTH        = 10,
    parameter int          BALL_SIZE           = 8,
    parameter int          PADDLE_SPEED        = 4,
    parameter int          BALL_SPEED          = 2,
    parameter int          WIN_SCORE           = 7,
    parameter int          SERVE_FRAMES        = 60,
    parameter int          L_PADDLE_CENTER_COL = 55,
    parameter int          R_PADDLE_CENTER_COL = DISP_COLS - 55,
    parameter logic [7:0]  OBJ_COLOR           = 8'hFF,
    localparam int         SW                  = $clog2(WIN_SCORE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          move_up_p0,
    input  logic          move_down_p0,
    input  logic          move_up_p1,
    input  logic          move_down_p1,
    input  logic          select_l_player,
    input  logic          select_r_player,
    input  logic [11:0]   col_counter,
    input  logic [11:0]   row_counter,
    output logic [7:0]    rgb,
    output logic [SW-1:0] score_l,
    output logic [SW-1:0] score_r,
    output logic          game_over
);

    typedef enum logic [2:0] {
        IDLE, SERVE, PLAY, POINT, GAME_OVER
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [12:0] PAD_MIN  = 13'(PADDLE_HEIGHT / 2);
    localparam logic signed [12:0] PAD_MAX  = 13'(DISP_ROWS - 1 - PADDLE_HEIGHT / 2);
    localparam logic signed [12:0] PSPD     = 13'(PADDLE_SPEED);
    localparam logic signed [12:0] BSPD     = 13'(BALL_SPEED);
    localparam logic signed [12:0] HPH      = 13'(PADDLE_HEIGHT / 2);
    localparam logic signed [12:0] HPW      = 13'(PADDLE_WIDTH / 2);
    localparam logic signed [12:0] HB       = 13'(BALL_SIZE / 2);
    localparam logic signed [12:0] L_COL    = 13'(L_PADDLE_CENTER_COL);
    localparam logic signed [12:0] R_COL    = 13'(R_PADDLE_CENTER_COL);
    localparam logic signed [12:0] ROW_LAST = 13'(DISP_ROWS - 1);
    localparam logic signed [12:0] COL_LAST = 13'(DISP_COLS - 1);
    localparam logic signed [12:0] ONE      = 13'sd1;
    localparam logic [11:0]        COL_MID  = 12'(DISP_COLS / 2);
    localparam logic [11:0]        ROW_MID  = 12'(DISP_ROWS / 2);
    localparam logic [11:0]        BSTEP    = 12'(BALL_SPEED);
    localparam logic [SW-1:0]      WIN      = SW'(WIN_SCORE);
    localparam logic [CW-1:0]      SERVE_LAST = CW'(SERVE_FRAMES - 1);

    function automatic logic signed [12:0] s13(input logic [11:0] v);
        return signed'({1'b0, v});
    endfunction

    // Signed 13-bit so the clamp sees negative/overflowing results before truncation.
    function automatic logic [11:0] paddle_next(input logic [11:0] c, input logic player,
                                                input logic up, input logic dn,
                                                input logic [11:0] ball_row);
        logic signed [12:0] cs;
        logic signed [12:0] bs;
        logic signed [12:0] n;
        cs = s13(c);
        bs = s13(ball_row);
        n  = cs;
        if (player) begin
            if (up && !dn)      n = cs - PSPD;
            else if (dn && !up) n = cs + PSPD;
        end else begin
            if (bs > cs + PSPD)      n = cs + PSPD;
            else if (bs < cs - PSPD) n = cs - PSPD;
        end
        if (n < PAD_MIN)      n = PAD_MIN;
        else if (n > PAD_MAX) n = PAD_MAX;
        return n[11:0];
    endfunction

    function automatic logic in_box(input logic signed [12:0] px, py, cx, cy, hw, hh);
        return (px >= cx - hw) && (px <= cx + hw - ONE) &&
               (py >= cy - hh) && (py <= cy + hh - ONE);
    endfunction

    state_t          state_q, state_d;
    logic            tick_q;
    logic [11:0]     lpad_q, lpad_d, rpad_q, rpad_d;
    logic [11:0]     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic            dx_q, dx_d, dy_q, dy_d;      // 1 = positive direction
    logic            serve_dir_q, serve_dir_d;    // 1 = next serve goes right
    logic [SW-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
    logic [CW-1:0]   serve_cnt_q, serve_cnt_d;
    logic [7:0]      rgb_q, rgb_d;

    // Ball edges and collision terms for the current tick.
    logic signed [12:0] b_top, b_bot, b_left, b_right;
    logic               wall, hit_l, hit_r, dx_n, dy_n, miss_l, miss_r;

    assign b_top   = s13(ball_y_q) - HB;
    assign b_bot   = s13(ball_y_q) + HB - ONE;
    assign b_left  = s13(ball_x_q) - HB;
    assign b_right = s13(ball_x_q) + HB - ONE;

    assign wall  = (!dy_q && (b_top <= BSPD)) || (dy_q && (b_bot >= ROW_LAST - BSPD));
    assign hit_l = !dx_q && (b_left >= L_COL - HPW) && (b_left <= L_COL + HPW - ONE + BSPD)
                   && (b_top <= s13(lpad_q) + HPH - ONE) && (b_bot >= s13(lpad_q) - HPH);
    assign hit_r = dx_q && (b_right <= R_COL + HPW - ONE) && (b_right >= R_COL - HPW - BSPD)
                   && (b_top <= s13(rpad_q) + HPH - ONE) && (b_bot >= s13(rpad_q) - HPH);
    assign dy_n   = wall ? !dy_q : dy_q;
    assign dx_n   = hit_l ? 1'b1 : (hit_r ? 1'b0 : dx_q);
    // Miss uses the post-hit direction so a returned ball is not also scored.
    assign miss_l = !dx_n && (b_left <= BSPD);
    assign miss_r = dx_n && (b_right >= COL_LAST - BSPD);

    always_comb begin
        state_d     = state_q;
        lpad_d      = lpad_q;
        rpad_d      = rpad_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_dir_d = serve_dir_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_cnt_d = serve_cnt_q;
        if (tick_q) begin
            lpad_d = paddle_next(lpad_q, select_l_player, move_up_p0, move_down_p0, ball_y_q);
            rpad_d = paddle_next(rpad_q, select_r_player, move_up_p1, move_down_p1, ball_y_q);
            unique case (state_q)
                IDLE: begin
                    ball_x_d = COL_MID;
                    ball_y_d = ROW_MID;
                    if (start) begin
                        serve_cnt_d = '0;
                        state_d     = SERVE;
                    end
                end
                SERVE: begin
                    ball_x_d    = COL_MID;
                    ball_y_d    = ROW_MID;
                    dx_d        = serve_dir_q;
                    serve_cnt_d = serve_cnt_q + 1'b1;
                    if (serve_cnt_q == SERVE_LAST) state_d = PLAY;
                end
                PLAY: begin
                    dx_d = dx_n;
                    dy_d = dy_n;
                    if (miss_l) begin
                        if (score_r_q < WIN) score_r_d = score_r_q + 1'b1;
                        serve_dir_d = 1'b0;
                        state_d     = POINT;
                    end else if (miss_r) begin
                        if (score_l_q < WIN) score_l_d = score_l_q + 1'b1;
                        serve_dir_d = 1'b1;
                        state_d     = POINT;
                    end else begin
                        ball_x_d = dx_n ? ball_x_q + BSTEP : ball_x_q - BSTEP;
                        ball_y_d = dy_n ? ball_y_q + BSTEP : ball_y_q - BSTEP;
                    end
                end
                POINT: begin
                    ball_x_d    = COL_MID;
                    ball_y_d    = ROW_MID;
                    serve_cnt_d = '0;
                    state_d     = ((score_l_q == WIN) || (score_r_q == WIN)) ? GAME_OVER : SERVE;
                end
                GAME_OVER: begin
                    if (start) begin
                        score_l_d   = '0;
                        score_r_d   = '0;
                        serve_cnt_d = '0;
                        state_d     = SERVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic pix_obj, pix_net;

    assign pix_obj = in_box(s13(col_counter), s13(row_counter), L_COL, s13(lpad_q), HPW, HPH)
                  || in_box(s13(col_counter), s13(row_counter), R_COL, s13(rpad_q), HPW, HPH)
                  || ((state_q != GAME_OVER) &&
                      in_box(s13(col_counter), s13(row_counter), s13(ball_x_q), s13(ball_y_q), HB, HB));
`ifdef CENTER_NET_EN
    assign pix_net = ((col_counter == COL_MID - 12'd1) || (col_counter == COL_MID)) && !row_counter[4];
`else
    assign pix_net = 1'b0;
`endif
    assign rgb_d = (pix_obj || pix_net) ? OBJ_COLOR : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_q      <= 1'b0;
            lpad_q      <= ROW_MID;
            rpad_q      <= ROW_MID;
            ball_x_q    <= COL_MID;
            ball_y_q    <= ROW_MID;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            serve_dir_q <= 1'b1;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_cnt_q <= '0;
            rgb_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            tick_q      <= (col_counter == 12'(DISP_COLS - 1)) && (row_counter == 12'(DISP_ROWS - 1));
            lpad_q      <= lpad_d;
            rpad_q      <= rpad_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_dir_q <= serve_dir_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_cnt_q <= serve_cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine
// Directed bench for pong_game_engine with default parameters. Frame ticks
// are produced by driving the counters to the last visible pixel for one
// cycle; object positions are read back through the rendered rgb stream.
module tb_pong_game_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        move_up_p0, move_down_p0, move_up_p1, move_down_p1;
    logic        select_l_player, select_r_player;
    logic [11:0] col_counter, row_counter;
    logic [7:0]  rgb;
    logic [2:0]  score_l, score_r;
    logic        game_over;

    int n_cmp;
    int n_err;

    pong_game_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .move_up_p0      (move_up_p0),
        .move_down_p0    (move_down_p0),
        .move_up_p1      (move_up_p1),
        .move_down_p1    (move_down_p1),
        .select_l_player (select_l_player),
        .select_r_player (select_r_player),
        .col_counter     (col_counter),
        .row_counter     (row_counter),
        .rgb             (rgb),
        .score_l         (score_l),
        .score_r         (score_r),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame tick; state reflects the tick when this returns.
    task automatic do_tick();
        col_counter = 12'd799;
        row_counter = 12'd599;
        @(posedge clk); #1;
        col_counter = 12'd0;
        row_counter = 12'd0;
        @(posedge clk); #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic probe_chk(input string tag, input int c, input int r, input logic [7:0] exp);
        col_counter = 12'(c);
        row_counter = 12'(r);
        @(posedge clk); #1;
        check_eq(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic do_reset();
        col_counter = 12'd0;
        row_counter = 12'd0;
        start = 1'b0;
        move_up_p0 = 1'b0; move_down_p0 = 1'b0;
        move_up_p1 = 1'b0; move_down_p1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        move_up_p0 = 1'b0; move_down_p0 = 1'b0;
        move_up_p1 = 1'b0; move_down_p1 = 1'b0;
        select_l_player = 1'b0;
        select_r_player = 1'b0;
        col_counter = 12'd0;
        row_counter = 12'd0;
        n_cmp = 0;
        n_err = 0;

        #12;
        check_eq("rst_rgb", 32'(rgb), 32'h0);
        check_eq("rst_score_l", 32'(score_l), 32'd0);
        check_eq("rst_score_r", 32'(score_r), 32'd0);
        check_eq("rst_game_over", 32'(game_over), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Render in IDLE: paddles at row 300, ball at (400,300).
        probe_chk("pad_l_centre", 55, 300, 8'hFF);
        col_counter = 12'd0;
        row_counter = 12'd0;
        #1;
        check_eq("rgb_latency_hold", 32'(rgb), 32'hFF);
        @(posedge clk); #1;
        check_eq("rgb_origin", 32'(rgb), 32'h0);
        probe_chk("pad_l_left_edge", 50, 280, 8'hFF);
        probe_chk("pad_l_left_out", 49, 280, 8'h00);
        probe_chk("pad_l_bottom", 59, 319, 8'hFF);
        probe_chk("pad_l_below", 59, 320, 8'h00);
        probe_chk("pad_r_centre", 745, 300, 8'hFF);
        probe_chk("pad_r_right_out", 750, 300, 8'h00);
        probe_chk("ball_idle_tl", 396, 296, 8'hFF);
        probe_chk("ball_idle_left_out", 395, 296, 8'h00);
`ifdef CENTER_NET_EN
        probe_chk("net_dash_on", 399, 0, 8'hFF);
        probe_chk("net_dash_gap", 399, 16, 8'h00);
        probe_chk("net_right_col", 400, 15, 8'hFF);
`else
        probe_chk("no_net", 399, 0, 8'h00);
`endif

        // Serve and rally, both paddles tracking.
        start = 1'b1;
        do_tick();
        start = 1'b0;
        tick_n(60);
        probe_chk("serve_held_centre", 396, 296, 8'hFF);
        probe_chk("serve_held_left_out", 395, 296, 8'h00);
        tick_n(1);
        probe_chk("play1_tl", 398, 298, 8'hFF);
        probe_chk("play1_left_out", 397, 298, 8'h00);
        probe_chk("play1_br", 405, 305, 8'hFF);
        probe_chk("play1_right_out", 406, 305, 8'h00);
        tick_n(146);
        probe_chk("near_floor_bottom", 690, 597, 8'hFF);
        probe_chk("near_floor_below", 690, 598, 8'h00);
        tick_n(1);
        probe_chk("floor_bounce_top", 692, 588, 8'hFF);
        probe_chk("floor_bounce_below", 692, 596, 8'h00);
        tick_n(21);
        probe_chk("r_hit_returned", 730, 546, 8'hFF);
        probe_chk("r_hit_not_through", 738, 546, 8'h00);
        tick_n(272);
        probe_chk("row6_top", 186, 2, 8'hFF);
        probe_chk("row6_above", 186, 1, 8'h00);
        tick_n(1);
        probe_chk("ceiling_bounce_row8", 184, 4, 8'hFF);
        probe_chk("ceiling_bounce_above", 184, 3, 8'h00);
        tick_n(63);
        probe_chk("l_hit_returned", 69, 130, 8'hFF);
        probe_chk("l_hit_not_through", 61, 130, 8'h00);
        tick_n(10);
        probe_chk("ball_before_reset", 86, 154, 8'hFF);

        // Asynchronous reset mid-game.
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rgb", 32'(rgb), 32'h0);
        check_eq("midrst_game_over", 32'(game_over), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        probe_chk("midrst_ball_centre", 396, 296, 8'hFF);
        probe_chk("midrst_pad_l_top", 55, 280, 8'hFF);
        probe_chk("midrst_pad_l_above", 55, 279, 8'h00);

        // Player paddle movement and clamp.
        select_l_player = 1'b1;
        move_up_p0 = 1'b1;
        tick_n(1);
        probe_chk("pad_up_one_top", 55, 276, 8'hFF);
        probe_chk("pad_up_one_above", 55, 275, 8'h00);
        tick_n(199);
        probe_chk("pad_clamp_row0", 55, 0, 8'hFF);
        probe_chk("pad_clamp_row39", 55, 39, 8'hFF);
        probe_chk("pad_clamp_row40", 55, 40, 8'h00);
        move_down_p0 = 1'b1;
        tick_n(5);
        probe_chk("pad_both_row39", 55, 39, 8'hFF);
        probe_chk("pad_both_row40", 55, 40, 8'h00);
        move_up_p0 = 1'b0;
        tick_n(1);
        probe_chk("pad_down_row43", 55, 43, 8'hFF);
        probe_chk("pad_down_row3", 55, 3, 8'h00);
        move_down_p0 = 1'b0;

        // Right paddle idle at 300: right misses, left scores.
        do_reset();
        select_l_player = 1'b0;
        select_r_player = 1'b1;
        start = 1'b1;
        do_tick();
        start = 1'b0;
        tick_n(60 + 197);
        check_eq("miss_r_before_l", 32'(score_l), 32'd0);
        tick_n(1);
        check_eq("miss_r_score_l", 32'(score_l), 32'd1);
        check_eq("miss_r_score_r", 32'(score_r), 32'd0);
        tick_n(1);
        probe_chk("point_recentred", 396, 296, 8'hFF);
        tick_n(60);
        probe_chk("serve2_held", 396, 296, 8'hFF);
        tick_n(1);
        probe_chk("serve2_tl", 398, 294, 8'hFF);
        probe_chk("serve2_left_out", 397, 294, 8'h00);
        probe_chk("serve2_br", 405, 301, 8'hFF);
        probe_chk("serve2_below", 405, 302, 8'h00);

        // Left player parked at row 20, right tracking: right wins 7-0.
        do_reset();
        select_l_player = 1'b1;
        select_r_player = 1'b0;
        move_up_p0 = 1'b1;
        tick_n(70);
        move_up_p0 = 1'b0;
        probe_chk("park_row39", 55, 39, 8'hFF);
        probe_chk("park_row40", 55, 40, 8'h00);
        start = 1'b1;
        do_tick();
        start = 1'b0;
        for (int i = 0; i < 4000 && !game_over; i++) do_tick();
        check_eq("go_flag", 32'(game_over), 32'd1);
        check_eq("go_score_r", 32'(score_r), 32'd7);
        check_eq("go_score_l", 32'(score_l), 32'd0);
        probe_chk("go_ball_hidden", 400, 300, 8'h00);
        tick_n(3);
        check_eq("go_score_frozen", 32'(score_r), 32'd7);
        start = 1'b1;
        do_tick();
        start = 1'b0;
        check_eq("restart_score_r", 32'(score_r), 32'd0);
        check_eq("restart_score_l", 32'(score_l), 32'd0);
        check_eq("restart_game_over", 32'(game_over), 32'd0);
        probe_chk("restart_ball_shown", 400, 300, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Parametrised next-generation game core. Holds both paddle positions, ball position and velocity, the per-player score and a serve/play/game-over state machine.
- Each paddle can be driven by a player or by a built-in tracker, selected per side.
- Renders all objects into one 8-bit pixel stream from the display counters.
- Sits between the display timing generator (col/row counters) and the video output.

Parameters:
- DISP_COLS, 800, visible columns
- DISP_ROWS, 600, visible rows
- PADDLE_HEIGHT, 40, paddle height in pixels (even)
- PADDLE_WIDTH, 10, paddle width in pixels (even)
- BALL_SIZE, 8, ball edge length in pixels (even, square)
- PADDLE_SPEED, 4, paddle pixels moved per frame
- BALL_SPEED, 2, ball pixels per frame on each axis
- WIN_SCORE, 7, points needed to end the game
- SERVE_FRAMES, 60, frames the ball is held at centre before launch
- L_PADDLE_CENTER_COL, 55, left paddle centre column
- R_PADDLE_CENTER_COL, DISP_COLS-55, right paddle centre column
- OBJ_COLOR, 8'hFF, colour of paddles and ball

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, level; starts a game from IDLE or GAME_OVER
- move_up_p0, input, 1, left player up
- move_down_p0, input, 1, left player down
- move_up_p1, input, 1, right player up
- move_down_p1, input, 1, right player down
- select_l_player, input, 1, 1 = left paddle player-driven, 0 = tracker-driven
- select_r_player, input, 1, 1 = right paddle player-driven, 0 = tracker-driven
- col_counter, input, 12, current pixel column
- row_counter, input, 12, current pixel row
- rgb, output, 8, pixel colour
- score_l, output, SW = $clog2(WIN_SCORE+1), left score
- score_r, output, SW, right score
- game_over, output, 1, high in GAME_OVER

Behaviour:
- Clocking and reset: single clock domain, clk. rst_n is asynchronous and active-low. All state is reset asynchronously.
- Reset values:
  - paddle centre rows = DISP_ROWS/2
  - ball = (DISP_COLS/2, DISP_ROWS/2), dx = +1, dy = +1
  - scores = 0, serve counter = 0
  - state = IDLE, rgb = 0, game_over = 0
- Frame tick: internal one-cycle pulse, registered, when col_counter == DISP_COLS-1 and row_counter == DISP_ROWS-1. All motion updates happen only on a tick.
- Paddles, on every tick in every state:
  - Player mode: up-only subtracts PADDLE_SPEED; down-only adds it; both or neither means no move.
  - Tracker mode: moves PADDLE_SPEED toward the ball row; no move if within PADDLE_SPEED of it.
  - Result is clamped to [PADDLE_HEIGHT/2, DISP_ROWS-1-PADDLE_HEIGHT/2].
  - Arithmetic is in 13-bit signed so the clamp is applied before any truncation.
- FSM states: IDLE, SERVE, PLAY, POINT, GAME_OVER.
- IDLE:
  - Ball held at centre.
  - start on a tick -> SERVE, serve counter = 0.
- SERVE:
  - Ball held at centre; counter increments each tick.
  - counter == SERVE_FRAMES-1 on a tick -> PLAY.
  - dx = toward the player who conceded the last point (+1 after reset).
  - dy keeps its previous value.
- PLAY, per tick, in this order:
  1. Vertical: if dy < 0 and top edge <= BALL_SPEED, or dy > 0 and bottom edge >= DISP_ROWS-1-BALL_SPEED, then flip dy before moving.
  2. Paddle hit:
     - Condition: dx < 0, ball left edge within [L paddle left edge, L paddle right edge + BALL_SPEED], and the ball row range overlaps the paddle row range.
     - Action: dx = +1.
     - The right paddle is mirrored.
  3. Miss: if dx < 0 and left edge <= BALL_SPEED, right scores (score_r += 1) -> POINT. The right side is mirrored.
  4. Otherwise the ball moves by (dx·BALL_SPEED, dy·BALL_SPEED).
  - A wall bounce and a paddle hit on the same tick are both applied.
- POINT:
  - Lasts one tick. Ball recentred.
  - If either score == WIN_SCORE -> GAME_OVER, else -> SERVE.
- GAME_OVER:
  - game_over = 1; scores frozen; ball hidden.
  - start on a tick -> scores cleared, SERVE.
- Scores never exceed WIN_SCORE; no wrap.
- Render:
  - rgb is registered, 1-cycle latency from the counters.
  - OBJ_COLOR when the pixel lies inside either paddle rectangle or the ball square (ball suppressed in GAME_OVER); else 0.
  - Rectangles use inclusive bounds: centre - size/2 through centre + size/2 - 1.
- Reset asserted mid-frame or mid-game returns everything to the reset values immediately. The first tick after release is processed normally.

Optional Feature:
- CENTER_NET_EN
  - Defined: rgb additionally shows OBJ_COLOR in columns DISP_COLS/2-1 and DISP_COLS/2 for rows where row_counter[4] == 0, forming a dashed net. Objects and the net are ORed.
  - Undefined: no net; the logic is absent.

Test Plan:
- Reset, start=1 for one tick, both in tracker mode -> after 60 ticks state is PLAY; the next tick moves the ball to (402,302).
- Left player holds up_p0 for 200 ticks -> left centre row saturates at 20 and stays there. With up and down held together, the row is unchanged.
- Ball placed at row 6 with dy=-1 in PLAY -> the next tick gives dy=+1 and row 8.
- Right paddle forced far from the ball (player mode, idle) while the ball travels right -> score_r unchanged, score_l=1, POINT then SERVE, and the next serve has dx=+1.
- Left paddle in player mode and idle at row 20, right in tracker mode -> after 7 points game_over=1 and score_r=7; start -> scores 0 and state SERVE.
- Counters at (55,300) with left paddle centred at 300 -> rgb=8'hFF one cycle later; counters at (0,0) -> rgb=0. With CENTER_NET_EN, (399,0) gives 8'hFF and (399,16) gives 0.
